// File: rtl/aes_axi_stream.sv
// AES-128 encryption engine behind a pair of 32-bit AXI-Stream ports.
// The first word of each input packet selects SET_KEY (0x10), ENCRYPT (0x20), or an unknown command.
// Each block runs one AddRoundKey at load time, then 10 rounds with the round key expanded on the fly.
// Optional feature: define AES_KEY_ACK_EN to emit a 4-word all-zero acknowledgement after SET_KEY.
module aes_axi_stream (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast
);

  localparam logic [31:0] CmdSetKey  = 32'h0000_0010;
  localparam logic [31:0] CmdEncrypt = 32'h0000_0020;

  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [2:0] {
    StIdle, StKeyLoad, StBlkLoad, StRounds, StOut, StAckOut, StDiscard
  } state_t;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[8'd255 - x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Byte i of the state is bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic final_rnd);
    logic [7:0]   sb [16];
    logic [127:0] sr, mc;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) sr[127-8*(4*c+r) -: 8] = sb[4*((c+r)%4)+r];
    end
    for (int c = 0; c < 4; c++) mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    return (final_rnd ? sr : mc) ^ rk;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rcon);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(k[23:16]) ^ rcon, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  state_t        r_fsm, w_fsm_nxt;
  logic [1:0]    r_cnt;
  logic [95:0]   r_blk;
  logic [127:0]  r_key, r_aes, r_rk;
  logic [7:0]    r_rcon;
  logic [3:0]    r_round;
  logic          r_last;

  logic          w_in_hs, w_out_hs;
  logic [127:0]  w_blk_full, w_rk_nxt, w_round_out;

  assign s_axis_tready = !areset &&
                         (r_fsm inside {StIdle, StKeyLoad, StBlkLoad, StDiscard});
  assign m_axis_tvalid = !areset && (r_fsm inside {StOut, StAckOut});
  assign w_in_hs       = s_axis_tvalid && s_axis_tready;
  assign w_out_hs      = m_axis_tvalid && m_axis_tready;
  assign w_blk_full    = {r_blk, s_axis_tdata};
  assign w_rk_nxt      = key_step(r_rk, r_rcon);
  assign w_round_out   = aes_round(r_aes, w_rk_nxt, r_round == 4'd10);

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) r_fsm <= StIdle;
    else        r_fsm <= w_fsm_nxt;
  end

  // Next-state decode plus output word/tlast selection.
  always_comb begin
    w_fsm_nxt    = r_fsm;
    m_axis_tdata = 32'h0;
    m_axis_tlast = 1'b0;
    unique case (r_fsm)
      StIdle: begin
        if (w_in_hs && !s_axis_tlast) begin
          if (s_axis_tdata == CmdSetKey)       w_fsm_nxt = StKeyLoad;
          else if (s_axis_tdata == CmdEncrypt) w_fsm_nxt = StBlkLoad;
          else                                 w_fsm_nxt = StDiscard;
        end
      end
      StKeyLoad: begin
        if (w_in_hs) begin
          if (r_cnt == 2'd3) begin
`ifdef AES_KEY_ACK_EN
            w_fsm_nxt = StAckOut;
`else
            w_fsm_nxt = s_axis_tlast ? StIdle : StDiscard;
`endif
          end else if (s_axis_tlast) begin
            w_fsm_nxt = StIdle;
          end
        end
      end
      StBlkLoad: begin
        if (w_in_hs) begin
          if (r_cnt == 2'd3)     w_fsm_nxt = StRounds;
          else if (s_axis_tlast) w_fsm_nxt = StIdle;
        end
      end
      StRounds: begin
        if (r_round == 4'd10) w_fsm_nxt = StOut;
      end
      StOut: begin
        case (r_cnt)
          2'd0:    m_axis_tdata = r_aes[127:96];
          2'd1:    m_axis_tdata = r_aes[95:64];
          2'd2:    m_axis_tdata = r_aes[63:32];
          default: m_axis_tdata = r_aes[31:0];
        endcase
        m_axis_tlast = r_last && (r_cnt == 2'd3);
        if (w_out_hs && r_cnt == 2'd3) w_fsm_nxt = r_last ? StIdle : StBlkLoad;
      end
      StAckOut: begin
        m_axis_tlast = (r_cnt == 2'd3);
        if (w_out_hs && r_cnt == 2'd3) w_fsm_nxt = r_last ? StIdle : StDiscard;
      end
      StDiscard: begin
        if (w_in_hs && s_axis_tlast) w_fsm_nxt = StIdle;
      end
      default: w_fsm_nxt = StIdle;
    endcase
    if (areset) begin
      m_axis_tdata = 32'h0;
      m_axis_tlast = 1'b0;
    end
  end

  // Datapath: word collection, key storage, round iteration and output word counter.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_cnt   <= 2'd0;
      r_blk   <= '0;
      r_key   <= '0;
      r_aes   <= '0;
      r_rk    <= '0;
      r_rcon  <= 8'h01;
      r_round <= 4'd0;
      r_last  <= 1'b0;
    end else begin
      case (r_fsm)
        StIdle: r_cnt <= 2'd0;
        StKeyLoad, StBlkLoad: begin
          if (w_in_hs) begin
            r_blk  <= w_blk_full[95:0];
            r_cnt  <= r_cnt + 2'd1;
            r_last <= s_axis_tlast;
            if (r_cnt == 2'd3) begin
              if (r_fsm == StKeyLoad) begin
                r_key <= w_blk_full;
              end else begin
                // Initial AddRoundKey is folded into the load.
                r_aes   <= w_blk_full ^ r_key;
                r_rk    <= r_key;
                r_rcon  <= 8'h01;
                r_round <= 4'd1;
              end
            end
          end
        end
        StRounds: begin
          r_aes   <= w_round_out;
          r_rk    <= w_rk_nxt;
          r_rcon  <= xtime(r_rcon);
          r_round <= r_round + 4'd1;
        end
        StOut, StAckOut: begin
          if (w_out_hs) r_cnt <= r_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_axi_stream.sv
// Directed bench for aes_axi_stream using FIPS-197 and well-known AES-128 vectors.
module tb_aes_axi_stream;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  int n_checks = 0;
  int n_pass   = 0;
  int phase    = 0;
  bit stall_en = 1'b0;

  localparam logic [127:0] KeyKung = 128'h5468617473206d79204b756e67204675;
  localparam logic [127:0] PtTwo   = 128'h54776f204f6e65204e696e652054776f;
  localparam logic [127:0] CtTwo   = 128'h29c3505f571420f6402299b31a02d73a;
  localparam logic [127:0] KeyFips = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PtFips  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CtFips  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CtZero  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_axi_stream dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Entered and left on a falling edge; the transfer happens on the rising edge in between.
  task automatic send_word(input logic [31:0] d, input logic last);
    int n = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (!s_axis_tready) check("s_tready timeout", 32'd0, 32'd1);
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] b, input logic last);
    send_word(b[127:96], 1'b0);
    send_word(b[95:64], 1'b0);
    send_word(b[63:32], 1'b0);
    send_word(b[31:0], last);
  endtask

  task automatic recv_block(input logic [127:0] b, input logic last, input string tag);
    for (int i = 0; i < 4; i++) begin
      int  n = 0;
      int  first_valid = -1;
      bit  got = 1'b0;
      while (n < 40) begin
        m_axis_tready = stall_en ? (phase < 6) : 1'b1;
        phase = (phase + 1) % 8;
        if (m_axis_tvalid && first_valid < 0) first_valid = n;
        if (m_axis_tvalid && m_axis_tready) begin
          got = 1'b1;
          break;
        end
        @(negedge aclk);
        n++;
      end
      if (i == 0) check({tag, " latency"}, 32'(first_valid >= 0 && first_valid <= 12), 32'd1);
      if (!got) begin
        check({tag, " timeout"}, 32'd0, 32'd1);
      end else begin
        check($sformatf("%s w%0d data", tag, i), m_axis_tdata, b[127-32*i -: 32]);
        check($sformatf("%s w%0d last", tag, i), 32'(m_axis_tlast), 32'(last && i == 3));
        @(negedge aclk);
      end
    end
  endtask

  task automatic quiet(input int cycles, input string tag);
    bit bad = 1'b0;
    m_axis_tready = 1'b1;
    repeat (cycles) begin
      if (m_axis_tvalid) bad = 1'b1;
      @(negedge aclk);
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic set_key(input logic [127:0] k, input string tag);
    send_word(32'h10, 1'b0);
    send_block(k, 1'b1);
`ifdef AES_KEY_ACK_EN
    recv_block(128'h0, 1'b1, {tag, " ack"});
`else
    quiet(16, {tag, " no ack"});
`endif
  endtask

  initial begin
    areset        = 1'b1;
    s_axis_tdata  = 32'h0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(negedge aclk);
    check("rst s_tready", 32'(s_axis_tready), 32'd0);
    check("rst m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst m_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst m_tdata", m_axis_tdata, 32'd0);
    areset = 1'b0;
    @(negedge aclk);
    check("post-rst s_tready", 32'(s_axis_tready), 32'd1);

    // Zero key before any SET_KEY.
    send_word(32'h20, 1'b0);
    send_block(128'h0, 1'b1);
    recv_block(CtZero, 1'b1, "zero key");

    set_key(KeyKung, "kung key");
    send_word(32'h20, 1'b0);
    send_block(PtTwo, 1'b1);
    check("busy s_tready", 32'(s_axis_tready), 32'd0);
    recv_block(CtTwo, 1'b1, "two");

    // Backpressure: 6 cycles ready, 2 cycles stalled.
    stall_en = 1'b1;
    phase    = 0;
    send_word(32'h20, 1'b0);
    send_block(PtTwo, 1'b1);
    recv_block(CtTwo, 1'b1, "stall");
    stall_en = 1'b0;
    quiet(16, "stall no dup");

    // Two blocks in one packet.
    send_word(32'h20, 1'b0);
    send_block(PtTwo, 1'b0);
    recv_block(CtTwo, 1'b0, "dual b0");
    send_block(PtTwo, 1'b1);
    recv_block(CtTwo, 1'b1, "dual b1");

    // Unknown command is swallowed through tlast.
    send_word(32'h30, 1'b0);
    send_word(32'h1111_1111, 1'b0);
    send_word(32'h2222_2222, 1'b1);
    quiet(16, "unknown no out");
    check("unknown idle", 32'(s_axis_tready), 32'd1);

    // Short block aborts the packet.
    send_word(32'h20, 1'b0);
    send_word(32'hdead_beef, 1'b0);
    send_word(32'hcafe_f00d, 1'b1);
    quiet(16, "abort no out");
    send_word(32'h20, 1'b0);
    send_block(PtTwo, 1'b1);
    recv_block(CtTwo, 1'b1, "after abort");

    set_key(KeyFips, "fips key");
    send_word(32'h20, 1'b0);
    send_block(PtFips, 1'b1);
    recv_block(CtFips, 1'b1, "fips");

    // Reset while rounds are in progress.
    send_word(32'h20, 1'b0);
    send_block(PtFips, 1'b1);
    repeat (3) @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    quiet(20, "mid-rst no out");
    check("mid-rst idle", 32'(s_axis_tready), 32'd1);
    send_word(32'h20, 1'b0);
    send_block(128'h0, 1'b1);
    recv_block(CtZero, 1'b1, "rst key0");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_axi_stream.md
AES_AXI_STREAM -- requirements
Module: aes_axi_stream

Interface
REQ-001 SHALL have no parameters; all widths fixed (32-bit stream, AES-128).
REQ-002 aclk  input  1  single clock; all logic on rising edge.
REQ-003 areset  input  1  reset; synchronous, active-high.
REQ-004 s_axis_tdata  input  32  command/key/plaintext word.
REQ-005 s_axis_tvalid  input  1  input word valid.
REQ-006 s_axis_tready  output  1  block ready to accept an input word.
REQ-007 s_axis_tlast  input  1  last word of input packet.
REQ-008 m_axis_tdata  output  32  result word.
REQ-009 m_axis_tvalid  output  1  result word valid.
REQ-010 m_axis_tready  input  1  downstream ready.
REQ-011 m_axis_tlast  output  1  last word of output packet.

Function
REQ-012 SHALL transfer a word on either port only in a cycle where tvalid and tready are both high.
REQ-013 SHALL map each 32-bit word big-endian: tdata[31:24] is the earliest byte; the first word of a 128-bit block carries bits 127:96.
REQ-014 SHALL treat the first word of each input packet as a command: 32'h00000010 = SET_KEY, 32'h00000020 = ENCRYPT; any other value is UNKNOWN.
REQ-015 SET_KEY: the next 4 words SHALL be loaded as the 128-bit AES key, which is retained until the next SET_KEY or reset.
REQ-016 ENCRYPT: each following group of 4 words SHALL form one plaintext block, encrypted with AES-128 (FIPS-197) using the stored key.
REQ-017 Each encrypted block SHALL produce 4 ciphertext words on m_axis in block order; m_axis_tlast SHALL be high on the 4th word of the block whose input group ended with s_axis_tlast.
REQ-018 Core SHALL be iterative: 1 initial AddRoundKey plus 10 rounds at one round per cycle, with round keys expanded on the fly; the first ciphertext word SHALL be valid no later than 12 cycles after the 4th plaintext word is accepted.
REQ-019 SHALL accept input words back-to-back while collecting a block; s_axis_tready SHALL be low while a block is being computed or output words are pending.
REQ-020 Output words SHALL remain stable while m_axis_tvalid is high and m_axis_tready is low; arbitrary m_axis_tready stalls SHALL lose or duplicate no data.
REQ-021 FSM states: IDLE (await command) -> KEY_LOAD | BLK_LOAD; KEY_LOAD -> ACK_OUT or IDLE; BLK_LOAD -> ROUNDS -> OUT; OUT -> BLK_LOAD if packet not ended, else IDLE.
REQ-022 UNKNOWN command: SHALL consume and discard words through s_axis_tlast, produce no output, and return to IDLE.
REQ-023 tlast arriving before a 4-word group is complete SHALL abort the packet: partial words are discarded, no output is produced, and the FSM returns to IDLE.
REQ-024 ENCRYPT before any SET_KEY SHALL use the all-zero key.

Reset
REQ-025 On areset: FSM SHALL go to IDLE; s_axis_tready=0 during reset and 1 the cycle after it is released; m_axis_tvalid=0; m_axis_tlast=0; m_axis_tdata=0; key=0.
REQ-026 areset asserted mid-block or mid-output SHALL discard all in-flight data; no partial packet SHALL be emitted after reset.

Configuration
REQ-027 Macro AES_KEY_ACK_EN defined: a completed SET_KEY SHALL emit an acknowledgement of 4 words of 32'h00000000, with m_axis_tlast on the 4th word.
REQ-028 AES_KEY_ACK_EN undefined: SET_KEY SHALL produce no output, and KEY_LOAD returns directly to IDLE.

Verification
REQ-029 SET_KEY 5468617473206D79204B756E67204675 (AES_KEY_ACK_EN defined) -> 4 words 00000000, tlast on word 4.
REQ-030 ENCRYPT pt 54776F204F6E65204E696E652054776F with that key -> 29c3505f 571420f6 402299b3 1a02d73a, tlast on word 4.
REQ-031 SET_KEY 000102030405060708090a0b0c0d0e0f, then ENCRYPT 00112233445566778899aabbccddeeff -> 69c4e0d8 6a7b0430 d8cdb780 70b4c55a.
REQ-032 Repeat REQ-030 with m_axis_tready toggling 6 cycles high / 2 low -> identical words and order, no drops or duplicates.
REQ-033 ENCRYPT carrying two blocks (REQ-030 pt twice) in one packet -> 8 words (29c3505f...1a02d73a twice), tlast only on word 8.
REQ-034 areset pulsed during ROUNDS -> no output; a subsequent ENCRYPT uses key 0: pt 00000000000000000000000000000000 -> 66e94bd4 ef8a2c3b 884cfa59 ca342b2e.
